// File: rtl/spi_cfg_rom_pkg.sv
// Shared constants and the AD9517 configuration table for spi_cfg_rom and its sequencer.
// Each table word is one complete SPI write frame {R/W, W1, W0, A[12:0], D[7:0]}.
package spi_cfg_rom_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 24;
    localparam int CFG_LEN = 64;
    localparam int TBL_AW  = $clog2(CFG_LEN);

    localparam logic [DATA_W-1:0] END_MARKER = 24'hFFFFFF;

    typedef struct packed {
        logic        rw;
        logic [1:0]  w;
        logic [12:0] addr;
        logic [7:0]  data;
    } spi_word_t;

    // Single-byte write: R/W=0, W1W0=00.
    function automatic spi_word_t mk_wr(input logic [12:0] addr, input logic [7:0] data);
        return {3'b000, addr, data};
    endfunction

    localparam spi_word_t CFG_TABLE [0:CFG_LEN-1] = '{
        mk_wr(13'h000, 8'h3C),
        mk_wr(13'h000, 8'h18),
        mk_wr(13'h010, 8'h7C),
        mk_wr(13'h011, 8'h0A),
        mk_wr(13'h012, 8'h00),
        mk_wr(13'h013, 8'h04),
        mk_wr(13'h014, 8'h12),
        mk_wr(13'h015, 8'h00),
        mk_wr(13'h016, 8'h05),
        mk_wr(13'h017, 8'h00),
        mk_wr(13'h018, 8'h06),
        mk_wr(13'h019, 8'h00),
        mk_wr(13'h01A, 8'h00),
        mk_wr(13'h01B, 8'h00),
        mk_wr(13'h01C, 8'h02),
        mk_wr(13'h01D, 8'h00),
        mk_wr(13'h01E, 8'h00),
        // Fine delay adjust on the LVDS/CMOS outputs.
        mk_wr(13'h0A0, 8'h01),
        mk_wr(13'h0A1, 8'h00),
        mk_wr(13'h0A2, 8'h00),
        mk_wr(13'h0A3, 8'h01),
        mk_wr(13'h0A4, 8'h00),
        mk_wr(13'h0A5, 8'h00),
        mk_wr(13'h0A6, 8'h01),
        mk_wr(13'h0A7, 8'h00),
        mk_wr(13'h0A8, 8'h00),
        mk_wr(13'h0A9, 8'h01),
        mk_wr(13'h0AA, 8'h00),
        mk_wr(13'h0AB, 8'h00),
        mk_wr(13'h0F0, 8'h08),
        mk_wr(13'h0F1, 8'h08),
        mk_wr(13'h0F2, 8'h08),
        mk_wr(13'h0F3, 8'h08),
        mk_wr(13'h0F4, 8'h0A),
        mk_wr(13'h0F5, 8'h0A),
        mk_wr(13'h140, 8'h42),
        mk_wr(13'h141, 8'h42),
        mk_wr(13'h142, 8'h43),
        mk_wr(13'h143, 8'h43),
        // Channel divider ratios and phase offsets.
        mk_wr(13'h190, 8'h00),
        mk_wr(13'h191, 8'h80),
        mk_wr(13'h192, 8'h00),
        mk_wr(13'h193, 8'hBB),
        mk_wr(13'h194, 8'h00),
        mk_wr(13'h195, 8'h00),
        mk_wr(13'h196, 8'h00),
        mk_wr(13'h197, 8'h00),
        mk_wr(13'h198, 8'h00),
        mk_wr(13'h199, 8'h22),
        mk_wr(13'h19A, 8'h00),
        mk_wr(13'h19B, 8'h11),
        mk_wr(13'h19C, 8'h00),
        mk_wr(13'h19D, 8'h00),
        mk_wr(13'h19E, 8'h22),
        mk_wr(13'h19F, 8'h00),
        mk_wr(13'h1A0, 8'h11),
        mk_wr(13'h1A1, 8'h00),
        mk_wr(13'h1A2, 8'h00),
        mk_wr(13'h1A3, 8'h00),
        mk_wr(13'h1E0, 8'h02),
        mk_wr(13'h1E1, 8'h02),
        mk_wr(13'h230, 8'h00),
        mk_wr(13'h231, 8'h00),
        mk_wr(13'h232, 8'h01)
    };

endpackage

// File: rtl/spi_cfg_rom_if.sv
// Read port of the configuration ROM: the sequencer (master) drives ena/addra, the ROM returns douta.
interface spi_cfg_rom_if;
    import spi_cfg_rom_pkg::*;

    logic              ena;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] douta;

    modport master (output ena, output addra, input douta);
    modport slave  (input ena, input addra, output douta);

endinterface

// File: rtl/spi_cfg_rom.sv
// Clock-enabled single-port ROM holding the AD9517 SPI configuration sequence.
// Define SPI_CFG_ROM_OUTREG_EN to add a second output register (2-cycle read latency).
module spi_cfg_rom
    import spi_cfg_rom_pkg::*;
(
    input  logic          clka,
    input  logic          rsta_n,
    spi_cfg_rom_if.slave  rom
);

    logic [DATA_W-1:0] rom_word;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;

    // Slots past the populated table read as the end marker so the sequencer knows to stop.
    always_comb begin
        rom_word = END_MARKER;
        if (int'(rom.addra) < CFG_LEN) begin
            rom_word = CFG_TABLE[rom.addra[TBL_AW-1:0]];
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (rom.ena) begin
            dout_d = rom_word;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

`ifdef SPI_CFG_ROM_OUTREG_EN
    logic [DATA_W-1:0] dout2_d;
    logic [DATA_W-1:0] dout2_q;

    always_comb begin
        dout2_d = dout2_q;
        if (rom.ena) begin
            dout2_d = dout_q;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            dout2_q <= '0;
        end else begin
            dout2_q <= dout2_d;
        end
    end

    assign rom.douta = dout2_q;
`else
    assign rom.douta = dout_q;
`endif

endmodule

// File: tb/tb_spi_cfg_rom.sv
// Directed, table-driven bench for spi_cfg_rom; expected words are written out by hand below.
// Handles both the 1-cycle build and the SPI_CFG_ROM_OUTREG_EN 2-cycle build.
module tb_spi_cfg_rom;
    import spi_cfg_rom_pkg::*;

    typedef struct {
        logic        rst_n;
        logic        ena;
        logic [6:0]  addr;
        logic [23:0] exp;
        string       name;
    } vec_t;

    logic clka = 1'b0;
    logic rsta_n;

    spi_cfg_rom_if rom_bus ();

    spi_cfg_rom dut (
        .clka   (clka),
        .rsta_n (rsta_n),
        .rom    (rom_bus.slave)
    );

    always #5 clka = ~clka;

    logic [23:0] gold [0:63];
    vec_t        vecs [$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [23:0] s1 = 24'h0;
    logic [23:0] s2 = 24'h0;

    task automatic add(input logic rst_n, input logic ena, input logic [6:0] addr,
                       input logic [23:0] exp, input string name);
        vec_t v;
        v.rst_n = rst_n;
        v.ena   = ena;
        v.addr  = addr;
        v.exp   = exp;
        v.name  = name;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [23:0] req);
        total_cnt++;
        if (rom_bus.douta === req) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: douta=%06h required=%06h", name, rom_bus.douta, req);
        end
    endtask

    // exp is the 1-cycle-latency value; the 2-cycle build delays it by one enabled edge.
    task automatic applyStimulus(input vec_t v);
        logic [23:0] req;
        @(negedge clka);
        rsta_n        = v.rst_n;
        rom_bus.ena   = v.ena;
        rom_bus.addra = v.addr;
        if (!v.rst_n) begin
            #1;
            checkOutput({v.name, "/async"}, 24'h0);
        end
        @(posedge clka);
        #1;
        if (!v.rst_n) begin
            s1 = 24'h0;
            s2 = 24'h0;
        end else if (v.ena) begin
            s2 = s1;
            s1 = v.exp;
        end
`ifdef SPI_CFG_ROM_OUTREG_EN
        req = s2;
`else
        req = v.exp;
`endif
        checkOutput(v.name, req);
    endtask

    initial begin
        rsta_n        = 1'b0;
        rom_bus.ena   = 1'b0;
        rom_bus.addra = 7'd0;

        gold = '{
            24'h00003C, 24'h000018, 24'h00107C, 24'h00110A, 24'h001200, 24'h001304, 24'h001412, 24'h001500,
            24'h001605, 24'h001700, 24'h001806, 24'h001900, 24'h001A00, 24'h001B00, 24'h001C02, 24'h001D00,
            24'h001E00, 24'h00A001, 24'h00A100, 24'h00A200, 24'h00A301, 24'h00A400, 24'h00A500, 24'h00A601,
            24'h00A700, 24'h00A800, 24'h00A901, 24'h00AA00, 24'h00AB00, 24'h00F008, 24'h00F108, 24'h00F208,
            24'h00F308, 24'h00F40A, 24'h00F50A, 24'h014042, 24'h014142, 24'h014243, 24'h014343, 24'h019000,
            24'h019180, 24'h019200, 24'h0193BB, 24'h019400, 24'h019500, 24'h019600, 24'h019700, 24'h019800,
            24'h019922, 24'h019A00, 24'h019B11, 24'h019C00, 24'h019D00, 24'h019E22, 24'h019F00, 24'h01A011,
            24'h01A100, 24'h01A200, 24'h01A300, 24'h01E002, 24'h01E102, 24'h023000, 24'h023100, 24'h023201
        };

        add(1'b0, 1'b0, 7'd0,  24'h0, "reset0");
        add(1'b0, 1'b1, 7'd3,  24'h0, "reset_ena");
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 7'(i + 5), 24'h0, "idle_after_reset");
        add(1'b1, 1'b1, 7'd0,  24'h00003C, "single_read_0");
        for (int n = 0; n < 64; n++) add(1'b1, 1'b1, 7'(n), gold[n], $sformatf("sweep_%0d", n));
        add(1'b1, 1'b1, 7'd64,  24'hFFFFFF, "end_marker_64");
        add(1'b1, 1'b1, 7'd127, 24'hFFFFFF, "end_marker_127");
        add(1'b1, 1'b1, 7'd100, 24'hFFFFFF, "end_marker_100");
        add(1'b1, 1'b1, 7'd5,   24'h001304, "read_5");
        for (int i = 0; i < 10; i++) add(1'b1, 1'b0, 7'(i * 13), 24'h001304, $sformatf("hold_%0d", i));
        add(1'b1, 1'b1, 7'd1,  24'h000018, "read_1");
        add(1'b1, 1'b1, 7'd63, 24'h023201, "read_63");
        add(1'b1, 1'b1, 7'd0,  24'h00003C, "read_0_again");

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset asserted mid-cycle while reads are streaming; output must clear without a clock edge.
        @(posedge clka);
        #3;
        rsta_n = 1'b0;
        #1;
        checkOutput("reset_mid_read", 24'h0);
        s1 = 24'h0;
        s2 = 24'h0;
        @(posedge clka);
        #1;
        checkOutput("reset_held_through_edge", 24'h0);

        vecs.delete();
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 7'd63, 24'h0, "zero_after_release");
        add(1'b1, 1'b1, 7'd63, 24'h023201, "first_read_after_reset");
        add(1'b1, 1'b1, 7'd2,  24'h00107C, "read_2");
        add(1'b1, 1'b1, 7'd2,  24'h00107C, "read_2_again");
        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
